// File: rtl/hsem_pkg.sv
// Shared encodings for the HSEM lock arbiter: master count, owner codes,
// request opcodes and arbiter FSM states.
package hsem_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  // Owner table entry, two bits per semaphore
  localparam logic [1:0] OWN_FREE = 2'b00;
  localparam logic [1:0] OWN_M1   = 2'b01;
  localparam logic [1:0] OWN_M2   = 2'b10;

  // req_op encoding
  localparam logic OP_UNLOCK = 1'b0;
  localparam logic OP_LOCK   = 1'b1;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/hsem_rr_arb2.sv
// Two-way round-robin picker with its own pointer.
// Ports: clk/rst (async active-high), req[1:0] requesters, take (pick is
// consumed this cycle), pick_c (selected index, combinational), any_c.
// The pointer only advances on contested picks, so the loser of one contest
// is preferred in the next one.
module hsem_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick_c,
  output logic       any_c
);

  logic rr_q, rr_d;

  // Pick and pointer update
  always_comb begin
    pick_c = req[1];
    rr_d   = rr_q;
    any_c  = |req;
    if (req == 2'b11) begin
      pick_c = rr_q;
      if (take) rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/hsem_lock_arbiter.sv
// HSEM lock/unlock arbiter and owner table.
// Serialises lock/unlock requests from two masters, maintains the owner of
// each semaphore, and keeps sticky per-master freed-interrupt and
// illegal-unlock error bits with write-1-to-clear strobes.
// Ports: hclk/hreset (async active-high); req_valid/op/wait/id per master;
// req_ack per master + shared req_ok; int_clr/err_clr W1C strobes;
// int_status, err_status, sem_owner, busy (all registered).
module hsem_lock_arbiter
  import hsem_pkg::*;
#(
  parameter int unsigned NUM_SEM = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [NUM_MASTERS-1:0]         req_valid,
  input  logic [NUM_MASTERS-1:0]         req_op,
  input  logic [NUM_MASTERS-1:0]         req_wait,
  input  logic [NUM_MASTERS*ID_W-1:0]    req_id,
  output logic [NUM_MASTERS-1:0]         req_ack,
  output logic                           req_ok,
  input  logic [NUM_MASTERS*NUM_SEM-1:0] int_clr,
  input  logic [NUM_MASTERS*NUM_SEM-1:0] err_clr,
  output logic [NUM_MASTERS*NUM_SEM-1:0] int_status,
  output logic [NUM_MASTERS*NUM_SEM-1:0] err_status,
  output logic [2*NUM_SEM-1:0]           sem_owner,
  output logic                           busy
);

  localparam int unsigned BITS = NUM_MASTERS * NUM_SEM;
  localparam int unsigned IW   = $clog2(BITS);

  logic [1:0]         state_q, state_d;
  logic               m_q, m_d;
  logic               op_q, op_d;
  logic               wt_q, wt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [2*NUM_SEM-1:0] owner_q, owner_d;
  logic [BITS-1:0]    wait_q, wait_d;
  logic [BITS-1:0]    int_q, int_d;
  logic [BITS-1:0]    err_q, err_d;
  logic [1:0]         ack_q, ack_d;
  logic               ok_q, ok_d;
  logic               busy_q, busy_d;

  logic               take_c;
  logic               pick_c;
  logic               any_c;

  hsem_rr_arb2 u_rr (
    .clk    (hclk),
    .rst    (hreset),
    .req    (req_valid),
    .take   (take_c),
    .pick_c (pick_c),
    .any_c  (any_c)
  );

  // Next-state, owner table and status update
  always_comb begin
    logic [1:0]    mine;
    logic [1:0]    cur;
    logic [IW-1:0] me_i;
    logic [IW-1:0] ot_i;

    state_d = state_q;
    m_d     = m_q;
    op_d    = op_q;
    wt_d    = wt_q;
    id_d    = id_q;
    owner_d = owner_q;
    wait_d  = wait_q;
    // W1C first so a same-cycle set from EXEC overrides the clear
    int_d   = int_q & ~int_clr;
    err_d   = err_q & ~err_clr;
    ack_d   = 2'b00;
    ok_d    = 1'b0;
    take_c  = 1'b0;
    mine    = m_q ? OWN_M2 : OWN_M1;
    cur     = OWN_FREE;
    me_i    = '0;
    ot_i    = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          take_c  = 1'b1;
          m_d     = pick_c;
          op_d    = req_op[pick_c];
          wt_d    = req_wait[pick_c];
          id_d    = pick_c ? req_id[2*ID_W-1:ID_W] : req_id[ID_W-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        ack_d[m_q]  = 1'b1;
        // Out-of-range ids match no entry: ok stays 0, nothing changes
        for (int unsigned s = 0; s < NUM_SEM; s++) begin
          if (id_q == ID_W'(s)) begin
            cur  = owner_q[2*s +: 2];
            me_i = IW'(m_q ? NUM_SEM + s : s);
            ot_i = IW'(m_q ? s : NUM_SEM + s);
            if (op_q == OP_LOCK) begin
              if (cur == OWN_FREE) begin
                owner_d[2*s +: 2] = mine;
                ok_d              = 1'b1;
              end else if (cur == mine) begin
                ok_d = 1'b1;
              end else if (wt_q) begin
                wait_d[me_i] = 1'b1;
              end
            end else begin
              wait_d[me_i] = 1'b0;
              if (cur == mine) begin
                owner_d[2*s +: 2] = OWN_FREE;
                ok_d              = 1'b1;
                if (wait_q[ot_i]) begin
                  int_d[ot_i]  = 1'b1;
                  wait_d[ot_i] = 1'b0;
                end
              end else begin
                err_d[me_i] = 1'b1;
              end
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      m_q     <= 1'b0;
      op_q    <= 1'b0;
      wt_q    <= 1'b0;
      id_q    <= '0;
      owner_q <= '0;
      wait_q  <= '0;
      int_q   <= '0;
      err_q   <= '0;
      ack_q   <= 2'b00;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      op_q    <= op_d;
      wt_q    <= wt_d;
      id_q    <= id_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      int_q   <= int_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ack    = ack_q;
  assign req_ok     = ok_q;
  assign int_status = int_q;
  assign err_status = err_q;
  assign sem_owner  = owner_q;
  assign busy       = busy_q;

endmodule
